// File: rtl/trap_ctrl.sv
// Trap/interrupt initiator at the commit stage: picks exceptions, MRET or interrupts,
// pulses the CSR unit, flushes the pipeline and redirects fetch through a valid/ack handshake.
module trap_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ext_irq_async,
    input  logic        timer_irq,
    input  logic        global_int_enable,
    input  logic [31:0] mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        commit_valid,
    input  logic [31:0] commit_next_pc,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic        mret_valid,
    output logic        trap_taken,
    output logic [31:0] trap_cause,
    output logic [31:0] trap_pc,
    output logic        mret_taken,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ack,
    output logic        irq_pending
);

    typedef enum logic [1:0] {IDLE, TRAP, MRET, REDIR} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [31:0]            cause_q, cause_d;
    logic [31:0]            epc_q, epc_d;
    logic                   is_irq_q, is_irq_d;
    logic [31:0]            rpc_q, rpc_d;

    logic        ext_sync, meip, mtip;
    logic [31:0] vec_base, vec_pc;
    logic        vec_hit;
    logic        unused;

    assign unused = ^{mie[31:12], mie[10:8], mie[6:0]};

    assign ext_sync    = sync_q[SYNC_STAGES-1];
    assign meip        = ext_sync & mie[11];
    assign mtip        = timer_irq & mie[7];
    assign irq_pending = (meip | mtip) & global_int_enable;

    // Only interrupts may vector; exceptions always land on the base address.
    assign vec_base = {mtvec[31:2], 2'b00};
    assign vec_hit  = VECTORED_EN && is_irq_q && (mtvec[1:0] == 2'b01);
    assign vec_pc   = vec_hit ? vec_base + {26'h0, cause_q[3:0], 2'b00} : vec_base;

    assign trap_cause  = cause_q;
    assign trap_pc     = epc_q;
    assign redirect_pc = rpc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            cause_q  <= '0;
            epc_q    <= '0;
            is_irq_q <= 1'b0;
            rpc_q    <= '0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], ext_irq_async};
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            is_irq_q <= is_irq_d;
            rpc_q    <= rpc_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        epc_d          = epc_q;
        is_irq_d       = is_irq_q;
        rpc_d          = rpc_q;
        trap_taken     = 1'b0;
        mret_taken     = 1'b0;
        pipe_flush     = 1'b0;
        redirect_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (exc_valid) begin
                    cause_d  = {28'h0, exc_cause};
                    epc_d    = exc_pc;
                    is_irq_d = 1'b0;
                    state_d  = TRAP;
                end else if (mret_valid) begin
                    state_d = MRET;
                end else if (irq_pending && commit_valid) begin
                    // An interrupt is only taken on a retiring instruction so epc is precise.
                    cause_d  = meip ? 32'h8000_000B : 32'h8000_0007;
                    epc_d    = commit_next_pc;
                    is_irq_d = 1'b1;
                    state_d  = TRAP;
                end
            end
            TRAP: begin
                trap_taken = 1'b1;
                pipe_flush = 1'b1;
                rpc_d      = vec_pc;
                state_d    = REDIR;
            end
            MRET: begin
                mret_taken = 1'b1;
                pipe_flush = 1'b1;
                rpc_d      = mepc;
                state_d    = REDIR;
            end
            REDIR: begin
                redirect_valid = 1'b1;
                pipe_flush     = 1'b1;
                if (redirect_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
